// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic MAC processing element.
// Holds the PE state encoding, default widths and product sign/zero extension.
package systolic_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pe_state_e;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 24;
    localparam int CNT_W_DEF  = 8;

    // Widest product/accumulator the extension helper supports.
    localparam int EXT_W = 128;

    // Extend a prod_w-bit product held in the low bits of prod to EXT_W bits.
    function automatic logic [EXT_W-1:0] extend_product(input logic [EXT_W-1:0] prod,
                                                        input int unsigned   prod_w,
                                                        input bit            is_signed);
        logic [EXT_W-1:0] r;
        int unsigned      sh;
        sh = EXT_W - prod_w;
        r  = prod << sh;
        if (is_signed) begin
            r = $signed(r) >>> sh;
        end else begin
            r = r >> sh;
        end
        return r;
    endfunction

endpackage

// File: rtl/systolic_mac_pe_if.sv
// Operand, passthrough and result-handshake bundle of one systolic MAC PE.
// master = array fabric / bench side, slave = the PE itself.
interface systolic_mac_pe_if
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();

    logic [DATA_W-1:0] in_n_data;
    logic              in_n_vld;
    logic [DATA_W-1:0] in_w_data;
    logic              in_w_vld;
    logic [CNT_W-1:0]  k_len;
    logic              clr;
    logic [DATA_W-1:0] out_s_data;
    logic              out_s_vld;
    logic [DATA_W-1:0] out_e_data;
    logic              out_e_vld;
    logic [ACC_W-1:0]  res_data;
    logic              res_vld;
    logic              res_rdy;
    logic              ovr;
    logic              misalign;

    modport master (
        output in_n_data, in_n_vld, in_w_data, in_w_vld, k_len, clr, res_rdy,
        input  out_s_data, out_s_vld, out_e_data, out_e_vld,
        input  res_data, res_vld, ovr, misalign
    );

    modport slave (
        input  in_n_data, in_n_vld, in_w_data, in_w_vld, k_len, clr, res_rdy,
        output out_s_data, out_s_vld, out_e_data, out_e_vld,
        output res_data, res_vld, ovr, misalign
    );

endinterface

// File: rtl/systolic_mac_unit.sv
// Combinational multiply, extend to ACC_W and accumulate for one PE.
// SYSTOLIC_MAC_PE_SAT_EN selects a saturating accumulate instead of modulo wrap.
module systolic_mac_unit
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SIGNED = 0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  acc,
    input  logic              first,
    output logic [ACC_W-1:0]  sum
);

    localparam int PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] prod;
    logic [EXT_W-1:0]  prod_wide;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  base;

    generate
        if (SIGNED != 0) begin : g_smul
            logic signed [PROD_W-1:0] prod_s;
            assign prod_s = PROD_W'($signed(a)) * PROD_W'($signed(b));
            assign prod   = prod_s;
        end else begin : g_umul
            assign prod = PROD_W'(a) * PROD_W'(b);
        end
    endgenerate

    assign prod_wide = extend_product(EXT_W'(prod), PROD_W, SIGNED != 0);
    assign prod_ext  = prod_wide[ACC_W-1:0];
    // The first beat of a tile starts from zero rather than the stale accumulator.
    assign base      = first ? '0 : acc;

`ifdef SYSTOLIC_MAC_PE_SAT_EN
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] x,
                                                 input logic [ACC_W-1:0] y);
        logic [ACC_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (SIGNED != 0) begin
            if ((x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1])) begin
                return x[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end
            return s[ACC_W-1:0];
        end
        // Unsigned products are never negative, so only the top can be exceeded.
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    assign sum = sat_add(base, prod_ext);
`else
    assign sum = base + prod_ext;
`endif

endmodule

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic MAC cell with operand forwarding and a one-deep result buffer.
// Define SYSTOLIC_MAC_PE_SAT_EN for a saturating accumulator.
module systolic_mac_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    systolic_mac_pe_if.slave  pe
);

    pe_state_e        state_p0;
    pe_state_e        state_nx;
    logic [ACC_W-1:0] acc_p0;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt_p0;
    logic [CNT_W-1:0] klen_p0;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W:0]   cnt_inc;
    logic             beat;
    logic             first;
    logic             last;
    logic             complete;
    logic             pop;

    assign beat     = pe.in_n_vld & pe.in_w_vld;
    assign pop      = pe.res_vld & pe.res_rdy;
    assign cnt_inc  = first ? (CNT_W+1)'(1) : {1'b0, cnt_p0} + (CNT_W+1)'(1);
    assign last     = beat & (cnt_inc == {1'b0, len_eff});
    assign complete = last & ~pe.clr;

    systolic_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .a     (pe.in_n_data),
        .b     (pe.in_w_data),
        .acc   (acc_p0),
        .first (first),
        .sum   (sum)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_nx;
        end
    end

    // Next state
    always_comb begin
        state_nx = state_p0;
        if (pe.clr) begin
            state_nx = IDLE;
        end else if (beat) begin
            state_nx = last ? IDLE : ACCUM;
        end
    end

    // FSM outputs: in IDLE the tile length comes straight from k_len (0 means 1)
    always_comb begin
        first   = 1'b0;
        len_eff = klen_p0;
        if (state_p0 == IDLE) begin
            first   = 1'b1;
            len_eff = (pe.k_len == '0) ? CNT_W'(1) : pe.k_len;
        end
    end

    // Accumulator, beat counter and latched tile length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p0  <= '0;
            cnt_p0  <= '0;
            klen_p0 <= '0;
        end else if (pe.clr) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
        end else if (beat) begin
            if (first) begin
                klen_p0 <= len_eff;
            end
            if (last) begin
                acc_p0 <= '0;
                cnt_p0 <= '0;
            end else begin
                acc_p0 <= sum;
                cnt_p0 <= cnt_inc[CNT_W-1:0];
            end
        end
    end

    // Operand forwarding, one cycle, independent of clr and pairing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe.out_s_data <= '0;
            pe.out_s_vld  <= 1'b0;
            pe.out_e_data <= '0;
            pe.out_e_vld  <= 1'b0;
        end else begin
            pe.out_s_data <= pe.in_n_data;
            pe.out_s_vld  <= pe.in_n_vld;
            pe.out_e_data <= pe.in_w_data;
            pe.out_e_vld  <= pe.in_w_vld;
        end
    end

    // Result buffer and sticky flags; a completion into a full, unpopped buffer is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe.res_data <= '0;
            pe.res_vld  <= 1'b0;
            pe.ovr      <= 1'b0;
            pe.misalign <= 1'b0;
        end else if (pe.clr) begin
            pe.res_vld  <= 1'b0;
            pe.ovr      <= 1'b0;
            pe.misalign <= 1'b0;
        end else begin
            if (pe.in_n_vld ^ pe.in_w_vld) begin
                pe.misalign <= 1'b1;
            end
            if (complete) begin
                if (!pe.res_vld || pop) begin
                    pe.res_data <= sum;
                    pe.res_vld  <= 1'b1;
                end else begin
                    pe.ovr <= 1'b1;
                end
            end else if (pop) begin
                pe.res_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: three configurations share one stimulus stream
// and are checked every cycle against an integer tile model plus literal expectations.
module tb_systolic_mac_pe;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] n_data = '0;
    logic       n_vld = 1'b0;
    logic [7:0] w_data = '0;
    logic       w_vld = 1'b0;
    logic [7:0] k_len = '0;
    logic       clr = 1'b0;
    logic       res_rdy = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

`ifdef SYSTOLIC_MAC_PE_SAT_EN
    localparam longint SAT_EXP = 65535;
`else
    localparam longint SAT_EXP = 64514;
`endif

    always #5 clk = ~clk;

    systolic_mac_pe_if #(.DATA_W(8), .ACC_W(24), .CNT_W(8)) ifa ();
    systolic_mac_pe_if #(.DATA_W(8), .ACC_W(24), .CNT_W(8)) ifb ();
    systolic_mac_pe_if #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) ifc ();

    systolic_mac_pe #(.DATA_W(8), .ACC_W(24), .CNT_W(8), .SIGNED(0)) u_a (.clk(clk), .rst(rst), .pe(ifa.slave));
    systolic_mac_pe #(.DATA_W(8), .ACC_W(24), .CNT_W(8), .SIGNED(1)) u_b (.clk(clk), .rst(rst), .pe(ifb.slave));
    systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .CNT_W(8), .SIGNED(0)) u_c (.clk(clk), .rst(rst), .pe(ifc.slave));

    assign ifa.in_n_data = n_data; assign ifb.in_n_data = n_data; assign ifc.in_n_data = n_data;
    assign ifa.in_n_vld  = n_vld;  assign ifb.in_n_vld  = n_vld;  assign ifc.in_n_vld  = n_vld;
    assign ifa.in_w_data = w_data; assign ifb.in_w_data = w_data; assign ifc.in_w_data = w_data;
    assign ifa.in_w_vld  = w_vld;  assign ifb.in_w_vld  = w_vld;  assign ifc.in_w_vld  = w_vld;
    assign ifa.k_len     = k_len;  assign ifb.k_len     = k_len;  assign ifc.k_len     = k_len;
    assign ifa.clr       = clr;    assign ifb.clr       = clr;    assign ifc.clr       = clr;
    assign ifa.res_rdy   = res_rdy; assign ifb.res_rdy  = res_rdy; assign ifc.res_rdy  = res_rdy;

    // DUT outputs gathered into arrays for the per-cycle compare
    logic [7:0]  d_sd[3], d_ed[3];
    logic        d_sv[3], d_ev[3], d_rv[3], d_ovr[3], d_mis[3];
    logic [23:0] d_rd[3];

    assign d_sd[0] = ifa.out_s_data; assign d_sd[1] = ifb.out_s_data; assign d_sd[2] = ifc.out_s_data;
    assign d_ed[0] = ifa.out_e_data; assign d_ed[1] = ifb.out_e_data; assign d_ed[2] = ifc.out_e_data;
    assign d_sv[0] = ifa.out_s_vld;  assign d_sv[1] = ifb.out_s_vld;  assign d_sv[2] = ifc.out_s_vld;
    assign d_ev[0] = ifa.out_e_vld;  assign d_ev[1] = ifb.out_e_vld;  assign d_ev[2] = ifc.out_e_vld;
    assign d_rv[0] = ifa.res_vld;    assign d_rv[1] = ifb.res_vld;    assign d_rv[2] = ifc.res_vld;
    assign d_ovr[0] = ifa.ovr;       assign d_ovr[1] = ifb.ovr;       assign d_ovr[2] = ifc.ovr;
    assign d_mis[0] = ifa.misalign;  assign d_mis[1] = ifb.misalign;  assign d_mis[2] = ifc.misalign;
    assign d_rd[0] = ifa.res_data;   assign d_rd[1] = ifb.res_data;   assign d_rd[2] = {8'h00, ifc.res_data};

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Tile model: configuration per instance
    int     cfg_aw[3] = '{24, 24, 16};
    bit     cfg_sg[3] = '{1'b0, 1'b1, 1'b0};

    logic [7:0] e_sd, e_ed;
    bit         e_sv, e_ev;
    bit         m_in[3], m_rv[3], m_ovr[3], m_mis[3];
    int         m_cnt[3], m_len[3];
    longint     m_sum[3], m_rd[3];
    bit         m_pop, m_done;

    function automatic longint opv(input logic [7:0] d, input bit sg);
        return sg ? longint'($signed(d)) : longint'({56'd0, d});
    endfunction

    function automatic longint mask_of(input int aw);
        return (longint'(1) << aw) - 1;
    endfunction

    function automatic longint add_prod(input longint s, input longint p, input int i);
        longint r;
        r = s + p;
`ifdef SYSTOLIC_MAC_PE_SAT_EN
        if (cfg_sg[i]) begin
            if (r > (longint'(1) << (cfg_aw[i]-1)) - 1) r = (longint'(1) << (cfg_aw[i]-1)) - 1;
            if (r < -(longint'(1) << (cfg_aw[i]-1)))    r = -(longint'(1) << (cfg_aw[i]-1));
        end else begin
            if (r > mask_of(cfg_aw[i])) r = mask_of(cfg_aw[i]);
        end
`endif
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_sd = '0; e_ed = '0; e_sv = 1'b0; e_ev = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_in[i] = 1'b0; m_rv[i] = 1'b0; m_ovr[i] = 1'b0; m_mis[i] = 1'b0;
                m_cnt[i] = 0; m_len[i] = 0; m_sum[i] = 0; m_rd[i] = 0;
            end
        end else begin
            e_sd = n_data; e_ed = w_data; e_sv = n_vld; e_ev = w_vld;
            for (int i = 0; i < 3; i++) begin
                m_pop  = m_rv[i] && res_rdy;
                m_done = 1'b0;
                if (clr) begin
                    m_in[i] = 1'b0; m_cnt[i] = 0; m_sum[i] = 0;
                    m_rv[i] = 1'b0; m_ovr[i] = 1'b0; m_mis[i] = 1'b0;
                end else begin
                    if (n_vld != w_vld) m_mis[i] = 1'b1;
                    if (n_vld && w_vld) begin
                        if (!m_in[i]) begin
                            m_in[i] = 1'b1; m_sum[i] = 0; m_cnt[i] = 0;
                            m_len[i] = (k_len == 0) ? 1 : int'(k_len);
                        end
                        m_sum[i] = add_prod(m_sum[i], opv(n_data, cfg_sg[i]) * opv(w_data, cfg_sg[i]), i);
                        m_cnt[i]++;
                        if (m_cnt[i] == m_len[i]) begin
                            m_done = 1'b1;
                            m_in[i] = 1'b0;
                        end
                    end
                    if (m_done && (!m_rv[i] || m_pop)) begin
                        m_rd[i] = m_sum[i] & mask_of(cfg_aw[i]);
                        m_rv[i] = 1'b1;
                    end else if (m_done) begin
                        m_ovr[i] = 1'b1;
                    end else if (m_pop) begin
                        m_rv[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("out_s_data[%0d]", i), longint'(d_sd[i]), longint'(e_sd));
                check($sformatf("out_s_vld[%0d]", i),  longint'(d_sv[i]), longint'(e_sv));
                check($sformatf("out_e_data[%0d]", i), longint'(d_ed[i]), longint'(e_ed));
                check($sformatf("out_e_vld[%0d]", i),  longint'(d_ev[i]), longint'(e_ev));
                check($sformatf("res_vld[%0d]", i),    longint'(d_rv[i]), longint'(m_rv[i]));
                check($sformatf("res_data[%0d]", i),   longint'(d_rd[i]), m_rd[i]);
                check($sformatf("ovr[%0d]", i),        longint'(d_ovr[i]), longint'(m_ovr[i]));
                check($sformatf("misalign[%0d]", i),   longint'(d_mis[i]), longint'(m_mis[i]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] n, input logic [7:0] w);
        n_data = n; w_data = w; n_vld = 1'b1; w_vld = 1'b1;
        cyc();
    endtask

    task automatic idle();
        n_vld = 1'b0; w_vld = 1'b0;
        cyc();
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_vld", longint'(ifa.res_vld), 0);
        check("rst_res_data", longint'(ifa.res_data), 0);
        check("rst_out_s_vld", longint'(ifa.out_s_vld), 0);
        check("rst_ovr", longint'(ifa.ovr), 0);
        check("rst_misalign", longint'(ifa.misalign), 0);
        rst = 1'b0;
        chk_on = 1'b1;

        // Reset in the middle of a k_len=4 tile, then a full tile of 3x5
        res_rdy = 1'b1; k_len = 8'd4;
        beat(8'd3, 8'd5); beat(8'd3, 8'd5);
        n_vld = 1'b0; w_vld = 1'b0;
        rst = 1'b1;
        #3;
        check("midrst_res_vld", longint'(ifa.res_vld), 0);
        check("midrst_out_s_vld", longint'(ifa.out_s_vld), 0);
        check("midrst_out_s_data", longint'(ifa.out_s_data), 0);
        rst = 1'b0;
        cyc();
        beat(8'd3, 8'd5); beat(8'd3, 8'd5); beat(8'd3, 8'd5);
        check("tile4_not_done", longint'(ifa.res_vld), 0);
        beat(8'd3, 8'd5);
        check("tile4_res_data", longint'(ifa.res_data), 60);
        check("tile4_res_vld", longint'(ifa.res_vld), 1);
        idle();
        check("tile4_popped", longint'(ifa.res_vld), 0);

        // Back-to-back k_len=2 tiles
        k_len = 8'd2;
        beat(8'd1, 8'd2); beat(8'd3, 8'd4);
        check("b2b_first", longint'(ifa.res_data), 14);
        beat(8'd5, 8'd6); beat(8'd7, 8'd8);
        check("b2b_second", longint'(ifa.res_data), 86);
        check("b2b_vld", longint'(ifa.res_vld), 1);
        check("b2b_ovr", longint'(ifa.ovr), 0);
        idle();

        // Overrun with the consumer stalled
        res_rdy = 1'b0; k_len = 8'd1;
        beat(8'd2, 8'd3); beat(8'd4, 8'd5);
        check("ovr_kept", longint'(ifa.res_data), 6);
        check("ovr_vld", longint'(ifa.res_vld), 1);
        check("ovr_flag", longint'(ifa.ovr), 1);
        res_rdy = 1'b1;
        idle();
        check("ovr_drain_vld", longint'(ifa.res_vld), 0);
        check("ovr_drain_hold", longint'(ifa.res_data), 6);

        // Signed vs unsigned on the same operand bytes
        k_len = 8'd3;
        beat(8'h80, 8'h80); beat(8'h7f, 8'hff); beat(8'hfe, 8'h03);
        check("signed_res", longint'(ifb.res_data), 16251);
        check("unsigned_res", longint'(ifa.res_data), 49531);
        idle();

        // k_len of zero behaves as one
        k_len = 8'd0;
        beat(8'd3, 8'd4);
        check("klen0_res", longint'(ifa.res_data), 12);
        check("klen0_vld", longint'(ifa.res_vld), 1);
        idle();

        // Misaligned cycle inside a tile, then clr with a discarded beat
        k_len = 8'd2;
        beat(8'd2, 8'd2);
        n_data = 8'd9; w_data = 8'd9; n_vld = 1'b1; w_vld = 1'b0;
        cyc();
        check("mis_flag", longint'(ifa.misalign), 1);
        check("mis_out_s_vld", longint'(ifa.out_s_vld), 1);
        check("mis_out_e_vld", longint'(ifa.out_e_vld), 0);
        res_rdy = 1'b0;
        beat(8'd3, 8'd3);
        check("mis_tile_res", longint'(ifa.res_data), 13);
        clr = 1'b1;
        beat(8'd5, 8'd5);
        clr = 1'b0;
        check("clr_misalign", longint'(ifa.misalign), 0);
        check("clr_res_vld", longint'(ifa.res_vld), 0);
        check("clr_ovr", longint'(ifa.ovr), 0);
        res_rdy = 1'b1; k_len = 8'd1;
        beat(8'd6, 8'd7);
        check("post_clr_res", longint'(ifa.res_data), 42);
        idle();

        // Accumulator range limit on the 16-bit instance
        k_len = 8'd2;
        beat(8'hff, 8'hff); beat(8'hff, 8'hff);
        check("sat16_res", longint'(ifc.res_data), SAT_EXP);
        check("wide_res", longint'(ifa.res_data), 130050);
        check("signed_m1_res", longint'(ifb.res_data), 2);
        idle();
        idle();

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_mac_pe.md
Name: systolic_mac_pe

Overview:
- Parametrised successor of the basic systolic processing element: one MAC cell of an R×C output-stationary array.
- Forwards north operands south and west operands east with valid qualification.
- Accumulates K operand pairs, then hands the finished dot product to a one-deep valid/ready result buffer and restarts on the next tile without a global reset.
- Optional signed arithmetic and saturation.

Parameters:
DATA_W, 8, operand width in bits
ACC_W, 24, accumulator/result width in bits; must be >= 2*DATA_W
CNT_W, 8, width of the k_len and beat counter
SIGNED, 0, 1 = operands and products are two's complement; 0 = unsigned

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_n_data  in  DATA_W  operand from north neighbour
in_n_vld  in  1  north operand valid
in_w_data  in  DATA_W  operand from west neighbour
in_w_vld  in  1  west operand valid
k_len  in  CNT_W  products per result; sampled on the first beat of each tile
clr  in  1  synchronous tile abort/clear
out_s_data  out  DATA_W  registered copy of in_n_data
out_s_vld  out  1  registered copy of in_n_vld
out_e_data  out  DATA_W  registered copy of in_w_data
out_e_vld  out  1  registered copy of in_w_vld
res_data  out  ACC_W  completed dot product
res_vld  out  1  res_data holds an unconsumed result
res_rdy  in  1  consumer accepts res_data when res_vld & res_rdy
ovr  out  1  sticky: a completed result was dropped
misalign  out  1  sticky: in_n_vld != in_w_vld in some cycle

Behaviour:
- Reset: all outputs, acc, beat counter and latched k_len go to 0; the FSM goes to IDLE. Reset is effective at any time, including mid-tile.
- Passthrough: out_s_*/out_e_* equal the inputs 1 cycle later, unconditionally. This includes clr cycles and cycles with a valid operand on only one side.
- Beat: a cycle with in_n_vld & in_w_vld. Product = in_n_data*in_w_data at width 2*DATA_W; signed if SIGNED=1 (both operands sign-extended), else zero-extended. The product is then extended to ACC_W.
- FSM:
  - IDLE: a beat latches k_len (0 treated as 1), sets acc <= product and count <= 1, and goes to ACCUM. If the latched length is 1, the tile completes on that same beat.
  - ACCUM: each beat does acc <= acc + product and count <= count+1.
  - Completion: on the beat where count+1 == latched length, the final sum (acc+product) is routed to the result buffer; acc and count clear; the FSM returns to IDLE.
- Latency: the final beat at edge t gives res_vld=1 with the result after edge t. No bubble is needed between tiles; a beat in the cycle after completion starts a new tile.
- Arithmetic: wrap-around modulo 2^ACC_W (see Optional Feature).
- Result buffer, one deep:
  - Pop when res_vld & res_rdy.
  - On completion: if the buffer is empty or popping in the same cycle, load res_data and keep res_vld=1. Otherwise drop the new result, keep the old one, and set ovr.
  - Pop with no completion clears res_vld. res_data holds its last value.
- misalign: set in any cycle where exactly one of in_n_vld/in_w_vld is 1. No beat occurs in that cycle. Cleared only by clr or rst.
- clr (sync, highest priority over beats): acc=0, count=0, FSM=IDLE, res_vld=0, ovr=0, misalign=0. A beat in the clr cycle is discarded.

Optional Feature:
- Macro: SYSTOLIC_MAC_PE_SAT_EN.
- Defined: the accumulate (including the first beat) saturates to the ACC_W range: [0, 2^ACC_W-1] for unsigned, [-2^(ACC_W-1), 2^(ACC_W-1)-1] for signed. Once saturated, the value stays clamped for the rest of the tile unless an opposite-sign product moves it back in range.
- Undefined: plain modulo wrap, and no saturation logic is synthesised.

Decomposition:
- Shared package systolic_pkg: FSM state enum (IDLE, ACCUM), default width constants DATA_W_DEF/ACC_W_DEF/CNT_W_DEF, and a function for product sign/zero-extension.
- One sub-module, systolic_mac_unit: combinational multiply plus extend plus (optional) saturating add. The parent holds all registers, the FSM and the result buffer.

Test Plan:
- Reset mid-tile: 2 beats of k_len=4, assert rst → all outputs 0, IDLE. Then 4 beats of 3×5 → res_data=60, res_vld=1 one cycle after the 4th beat.
- Back-to-back tiles, k_len=2, res_rdy=1: beats (1,2),(3,4),(5,6),(7,8) → res_data=14 then 86 on consecutive completions, ovr=0.
- Overrun: res_rdy=0, two k_len=1 tiles with 2×3 then 4×5 → res_data=6 kept, ovr=1. Then res_rdy=1 → res_vld falls the next cycle.
- Signed (SIGNED=1, DATA_W=8): k_len=3, beats (-128,-128),(127,-1),(-2,3) → res_data=16251.
- Misalign and clr: in_n_vld=1, in_w_vld=0 for 1 cycle → misalign=1, out_s_vld=1 next cycle, no acc change. Then clr → misalign=0, res_vld=0.
- SAT_EN, ACC_W=16, unsigned: k_len=2, beats (255,255),(255,255) → res_data=65535; without the macro → 64514.
